// File: rtl/abqm_pkg.sv
// Shared definitions for the bank queue manager: FSM encoding, queue count width
// and teller index width.
package abqm_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_HOLD = 2'b01
   } state_e;

   localparam int unsigned PCOUNT_W = 3;
   localparam logic [PCOUNT_W-1:0] PCOUNT_MAX = 3'b111;

   localparam int unsigned TELLER_IDX_W = 2;

endpackage

// File: rtl/teller_timer.sv
// One teller desk: a service countdown loaded at call time; busy while nonzero.
module teller_timer #(
   parameter int unsigned SVC_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [SVC_W-1:0] load_val,
   output logic             busy
);

   logic [SVC_W-1:0] timer_q, timer_d;

   always_comb begin
      timer_d = timer_q;
      if (load) begin
         timer_d = load_val;
      end else if (timer_q != '0) begin
         timer_d = timer_q - SVC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   assign busy = (timer_q != '0);

endmodule

// File: rtl/queue_server.sv
// Dequeue side of the bank queue manager: calls the next customer to the lowest free desk.
// Optional statistics outputs are enabled with QUEUE_SERVER_STATS_EN.
module queue_server
   import abqm_pkg::*;
#(
   parameter int unsigned N_TELLERS = 3,
   parameter int unsigned SVC_W     = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    open,
   input  logic                    in,
   input  logic                    empty,
   input  logic [PCOUNT_W-1:0]     pcount,
   input  logic [SVC_W-1:0]        svc_time,
   output logic                    out,
   output logic                    call_valid,
   output logic [TELLER_IDX_W-1:0] call_teller,
   output logic [N_TELLERS-1:0]    busy,
`ifdef QUEUE_SERVER_STATS_EN
   output logic                    all_busy,
   output logic [7:0]              served_cnt,
   output logic [2:0]              peak_busy
`else
   output logic                    all_busy
`endif
);

   state_e                  state_q, state_d;
   logic                    out_q;
   logic [TELLER_IDX_W-1:0] call_teller_q;
   logic                    call;
   logic                    call_ok;
   logic                    free_found;
   logic [TELLER_IDX_W-1:0] pick;
   logic [SVC_W-1:0]        svc_eff;
   logic [N_TELLERS-1:0]    load;

   // A zero service time would leave the desk free; treat it as one cycle.
   assign svc_eff = (svc_time == '0) ? SVC_W'(1) : svc_time;

   always_comb begin
      free_found = 1'b0;
      pick       = '0;
      for (int i = 0; i < N_TELLERS; i++) begin
         if (!busy[i] && !free_found) begin
            free_found = 1'b1;
            pick       = TELLER_IDX_W'(i);
         end
      end
   end

   // An arrival on the same cycle would collide with out at the queue FSM.
   assign call_ok = open && !empty && (pcount != '0) && !in && free_found;

   always_comb begin
      state_d = state_q;
      call    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (call_ok) begin
               call    = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         out_q         <= 1'b0;
         call_teller_q <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= call;
         if (call) begin
            call_teller_q <= pick;
         end
      end
   end

   for (genvar g = 0; g < N_TELLERS; g++) begin : g_desk
      assign load[g] = call && (pick == TELLER_IDX_W'(g));

      teller_timer #(
         .SVC_W(SVC_W)
      ) u_timer (
         .clk     (clk),
         .reset   (reset),
         .load    (load[g]),
         .load_val(svc_eff),
         .busy    (busy[g])
      );
   end

   assign out         = out_q;
   assign call_valid  = out_q;
   assign call_teller = call_teller_q;
   assign all_busy    = &busy;

`ifdef QUEUE_SERVER_STATS_EN
   logic [7:0] served_q;
   logic [2:0] peak_q;
   logic [2:0] busy_cnt;

   always_comb begin
      busy_cnt = '0;
      for (int i = 0; i < N_TELLERS; i++) begin
         busy_cnt = busy_cnt + 3'(busy[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         served_q <= '0;
         peak_q   <= '0;
      end else begin
         if (call && (served_q != 8'hFF)) begin
            served_q <= served_q + 8'd1;
         end
         if (busy_cnt > peak_q) begin
            peak_q <= busy_cnt;
         end
      end
   end

   assign served_cnt = served_q;
   assign peak_busy  = peak_q;
`endif

endmodule
